// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined LSL/LSR/ASR/ROL barrel shifter, one register per mux level,
// valid/ready handshake with a global stall when the result is not taken.
module shift_unit_pipe #(
    parameter int W  = 16,
    parameter int SW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [SW-1:0] in_sh,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_zero
);
    localparam int L = $clog2(W);

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k <= L; k++) begin : lv
        logic         v, sg;
        logic [W-1:0] d, nd;
        logic [L-1:0] a;
        logic [1:0]   m;
        if (k == 0) begin : g0
            logic over;
            // rotate ignores the over-shift bits, so its amount is naturally modulo W
            always_comb begin
                over = |in_sh[SW-1:L];
                nd   = (over && in_mode != 2'b11) ? {W{in_mode == 2'b10 && in_data[W-1]}} : in_data;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    v  <= 1'b0;
                    d  <= '0;
                    a  <= '0;
                    m  <= '0;
                    sg <= 1'b0;
                end else if (en) begin
                    v  <= in_valid;
                    d  <= nd;
                    a  <= in_sh[L-1:0];
                    m  <= in_mode;
                    sg <= in_data[W-1];
                end
            end
        end else begin : gk
            localparam int SH = 1 << (L - k);
            logic [W-1:0] pd;
            always_comb begin
                pd = lv[k-1].d;
                nd = !lv[k-1].a[L-k]     ? pd :
                     lv[k-1].m == 2'b00  ? pd << SH :
                     lv[k-1].m == 2'b01  ? pd >> SH :
                     lv[k-1].m == 2'b10  ? (pd >> SH) | ({W{lv[k-1].sg}} << (W - SH)) :
                                           (pd << SH) | (pd >> (W - SH));
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    v  <= 1'b0;
                    d  <= '0;
                    a  <= '0;
                    m  <= '0;
                    sg <= 1'b0;
                end else if (en) begin
                    v  <= lv[k-1].v;
                    d  <= nd;
                    a  <= lv[k-1].a;
                    m  <= lv[k-1].m;
                    sg <= lv[k-1].sg;
                end
            end
        end
    end

    // the last level only needs valid and data; the control fields end here
    logic unused;
    assign unused = ^{lv[L].a, lv[L].m, lv[L].sg};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
        end else if (en) begin
            out_valid <= lv[L].v;
            out_data  <= lv[L].d;
            out_zero  <= lv[L].d == '0;
        end
    end
endmodule

// File: doc/shift_unit_pipe.md
# shift_unit_pipe

Pipelined, parametrised barrel shifter for the datapath ALU. It extends the single-mode combinational 16-bit left shift to four modes: logical left, logical right, arithmetic right and rotate left. It is generic in data width and registers every mux level, so it closes timing at wider widths. A valid/ready handshake with full back-pressure lets the execute stage stall it without losing operations.

## Interface
- W, default 16: data width; power of two, 4..64.
- SW, default log2(W)+1: shift-amount width; the MSB carries the over-shift range (amount ≥ W).
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  an operation is offered.
- in_ready  out  1  the block will accept an operation this cycle.
- in_data  in  W  operand.
- in_sh  in  SW  shift amount, unsigned.
- in_mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROL.
- out_valid  out  1  a result is held on the outputs.
- out_ready  in  1  the consumer takes the result this cycle.
- out_data  out  W  shifted result.
- out_zero  out  1  asserted when out_data == 0.

## Operation
- L = log2(W). Pipeline has L+1 levels; each level has a register holding valid, data, remaining amount and mode.
- Level 0 (over-shift) takes the operand from in_data. When in_sh ≥ W:
  - LSL and LSR produce 0.
  - ASR produces all bits equal to in_data[W-1].
  - ROL does no over-shift; the amount is taken modulo W.
- Levels 1..L: level k shifts by 2^(L-k) when bit (L-k) of the amount is set. The level order is MSB first, the same decomposition as the 8/4/2/1 chain.
- Fill bits at each level:
  - LSL fills zeros on the right.
  - LSR fills zeros on the left.
  - ASR fills the sign bit, captured at level 0 and carried down the pipe.
  - ROL wraps the bits that are shifted out back in on the right.
- Shift amount 0 returns the operand unchanged in every mode.
- out_zero is computed from the final-level result and registered with it.
- Handshake:
  - An operation is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. Stall is global: when out_valid && !out_ready, no pipeline register updates.
  - Bubbles (invalid slots) flow through the pipe. They are not compressed.
- While stalled, out_data, out_zero and out_valid hold their values. in_data, in_sh and in_mode are don't-care unless the operation is accepted.

## Timing
- Latency: an operation accepted on edge N has out_valid high after edge N+L+1. That is 5 cycles for W=16.
- Throughput: one operation per cycle when out_ready is held high.
- Reset values, applied on any rising edge with rst high:
  - every valid bit, including out_valid, is 0;
  - out_data is 0;
  - out_zero is 0;
  - in_ready is 1 after reset.
- Reset mid-operation flushes all in-flight operations; none emerge later. An in_valid on the reset cycle is dropped.
- Simultaneous consume and accept on one edge: the pipe advances, the new operation enters level 0, and no data is lost or duplicated.
- The rst input and the registered outputs are not combinationally dependent on in_valid. in_ready depends combinationally on out_ready only.

## Test plan
- W=16, out_ready=1: the following ops each give out_valid exactly 5 cycles after acceptance.
  - LSL 0x00F1 by 4 -> 0x0F10.
  - LSR 0x8001 by 15 -> 0x0001.
  - ASR 0x8000 by 3 -> 0xF000.
  - ROL 0x8001 by 1 -> 0x0003.
- Over-shift:
  - LSL 0x1234 by 16 -> 0x0000 with out_zero=1.
  - LSR 0xFFFF by 31 -> 0x0000.
  - ASR 0x8000 by 17 -> 0xFFFF.
  - ASR 0x7FFF by 20 -> 0x0000.
  - ROL 0x8001 by 17 -> 0x0003.
- Back-to-back stream of 20 random ops with out_ready=1 -> 20 results, in order, on consecutive cycles, all matching the reference model.
- Back-pressure: hold out_ready=0 for 7 cycles mid-stream -> in_ready low while out_valid is high, outputs stable, then resume. The full sequence matches the model, with no drops and no duplicates.
- Reset mid-operation: assert rst for 1 cycle with 4 ops in flight -> out_valid=0, out_data=0 on the next cycle, and no stale results afterwards.
- Width sweep with W=32 and W=8, random ops including amount 0 and amount W-1 -> results match the model. Latency is 6 cycles for W=32 and 4 cycles for W=8.
